// File: rtl/buzzer_tone_driver_if.sv
// Handshake bundle between the alarm block and the piezo tone driver.
interface buzzer_tone_driver_if;
    logic [2:0] alarm_en;
    logic       tone_out;
    logic [2:0] chan_led;
    logic       busy;
    logic       cycle_done;

    modport master (output alarm_en, input tone_out, chan_led, busy, cycle_done);
    modport slave  (input alarm_en, output tone_out, chan_led, busy, cycle_done);
endinterface

// File: rtl/buzzer_tone_driver.sv
// Piezo tone/cadence driver: channel k plays k beeps at half-period HALF_DIV*k, then pauses.
// Optional macro LED_BLINK_EN: channel LEDs light only while a beep is sounding.
module buzzer_tone_driver #(
    parameter int HALF_DIV  = 4,
    parameter int BEEP_CYC  = 16,
    parameter int GAP_CYC   = 8,
    parameter int PAUSE_CYC = 32
) (
    input logic                  clk,
    input logic                  rst,
    buzzer_tone_driver_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BEEP, GAP, PAUSE} state_t;

    localparam logic [7:0] BEEP_LAST  = 8'(BEEP_CYC - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYC - 1);
    localparam logic [7:0] PAUSE_LAST = 8'(PAUSE_CYC - 1);
    localparam logic [7:0] HT1        = 8'(HALF_DIV - 1);
    localparam logic [7:0] HT2        = 8'(2 * HALF_DIV - 1);
    localparam logic [7:0] HT3        = 8'(3 * HALF_DIV - 1);

    state_t     state;
    logic [2:0] en_q;
    logic [1:0] ch, sel, beep_num;
    logic [7:0] dur, half_cnt, half_top;
    logic [2:0] quiet_led;
    logic       abort, preempt, start_new;

    function automatic logic [2:0] onehot(input logic [1:0] c);
        case (c)
            2'd1:    onehot = 3'b001;
            2'd2:    onehot = 3'b010;
            2'd3:    onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
    endfunction

    always_comb begin
        sel = 2'd0;
        if (en_q[2])      sel = 2'd3;
        else if (en_q[1]) sel = 2'd2;
        else if (en_q[0]) sel = 2'd1;
    end

    always_comb begin
        case (ch)
            2'd2:    half_top = HT2;
            2'd3:    half_top = HT3;
            default: half_top = HT1;
        endcase
    end

`ifdef LED_BLINK_EN
    assign quiet_led = 3'b000;
`else
    assign quiet_led = onehot(ch);
`endif

    // Abort outranks everything; a channel change in PAUSE is deferred to the pause end.
    assign abort     = (state != IDLE) && (sel == 2'd0);
    assign preempt   = ((state == BEEP) || (state == GAP)) && (sel != 2'd0) && (sel != ch);
    assign start_new = ((state == IDLE) && (sel != 2'd0)) || preempt ||
                       ((state == PAUSE) && (dur == PAUSE_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            en_q           <= '0;
            ch             <= '0;
            beep_num       <= '0;
            dur            <= '0;
            half_cnt       <= '0;
            bus.tone_out   <= 1'b0;
            bus.chan_led   <= '0;
            bus.busy       <= 1'b0;
            bus.cycle_done <= 1'b0;
        end else begin
            en_q           <= bus.alarm_en;
            bus.cycle_done <= 1'b0;
            if (abort) begin
                state        <= IDLE;
                ch           <= '0;
                beep_num     <= '0;
                dur          <= '0;
                half_cnt     <= '0;
                bus.tone_out <= 1'b0;
                bus.chan_led <= '0;
                bus.busy     <= 1'b0;
            end else if (start_new) begin
                state          <= BEEP;
                ch             <= sel;
                beep_num       <= 2'd1;
                dur            <= '0;
                half_cnt       <= '0;
                bus.tone_out   <= 1'b1;
                bus.busy       <= 1'b1;
                bus.chan_led   <= onehot(sel);
                bus.cycle_done <= (state == PAUSE);
            end else begin
                case (state)
                    BEEP: begin
                        if (dur == BEEP_LAST) begin
                            state        <= (beep_num == ch) ? PAUSE : GAP;
                            dur          <= '0;
                            half_cnt     <= '0;
                            bus.tone_out <= 1'b0;
                            bus.chan_led <= quiet_led;
                        end else begin
                            dur <= dur + 8'd1;
                            if (half_cnt == half_top) begin
                                half_cnt     <= '0;
                                bus.tone_out <= ~bus.tone_out;
                            end else begin
                                half_cnt <= half_cnt + 8'd1;
                            end
                        end
                    end
                    GAP: begin
                        if (dur == GAP_LAST) begin
                            state        <= BEEP;
                            beep_num     <= beep_num + 2'd1;
                            dur          <= '0;
                            half_cnt     <= '0;
                            bus.tone_out <= 1'b1;
                            bus.chan_led <= onehot(ch);
                        end else begin
                            dur <= dur + 8'd1;
                        end
                    end
                    PAUSE: dur <= dur + 8'd1;
                    default: begin
                        bus.tone_out <= 1'b0;
                        bus.chan_led <= '0;
                        bus.busy     <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_buzzer_tone_driver.sv
// Directed bench for buzzer_tone_driver at default parameters.
module tb_buzzer_tone_driver;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

`ifdef LED_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    buzzer_tone_driver_if bus ();

    buzzer_tone_driver #(.HALF_DIV(4), .BEEP_CYC(16), .GAP_CYC(8), .PAUSE_CYC(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected {tone, led[2:0], busy, cycle_done} for channel k, i cycles after pattern start.
    // Pattern: k beeps of 16 at half-period 4k, beep b starting at 24b, then 32-cycle pause.
    function automatic logic [5:0] exp_vec(input int k, input int i);
        int         p;
        logic       t, inb;
        logic [2:0] led;
        p   = i % (24 * k + 24);
        t   = 1'b0;
        inb = 1'b0;
        for (int b = 0; b < k; b++)
            if (p >= 24 * b && p < 24 * b + 16) begin
                inb = 1'b1;
                t   = (((p - 24 * b) / (4 * k)) % 2) == 0;
            end
        led = 3'b001;
        led = led << (k - 1);
        if (BLINK && !inb) led = 3'b000;
        return {t, led, 1'b1, (i > 0 && p == 0)};
    endfunction

    function automatic logic [5:0] obs();
        return {bus.tone_out, bus.chan_led, bus.busy, bus.cycle_done};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.alarm_en = 3'b000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Applies enables at a falling edge; the next rising edge is E0.
    task automatic start(input logic [2:0] en);
        @(negedge clk);
        bus.alarm_en = en;
        @(posedge clk);
    endtask

    task automatic test_reset();
        logic [5:0] o;
        rst = 1'b1;
        bus.alarm_en = 3'b001;
        repeat (3) @(negedge clk);
        o = obs();
        checks++;
        if (o !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000000", o);
        end
        @(negedge clk);
        bus.alarm_en = 3'b000;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        o = obs();
        checks++;
        if (o !== 6'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b want 000000", o);
        end
    endtask

    task automatic test_channel(input logic [2:0] en, input int k, input int n, input int want_cd);
        int bad = 0, first = -1, cd = 0;
        logic [5:0] fo = '0, fe = '0, o, e;
        do_reset();
        start(en);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            o = obs();
            e = exp_vec(k, i);
            if (bus.cycle_done === 1'b1) cd++;
            if (o !== e) begin
                bad++;
                if (first < 0) begin first = i; fo = o; fe = e; end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ch%0d_wave en=%b: %0d bad samples, first at %0d got %b want %b",
                     k, en, bad, first, fo, fe);
        end
        checks++;
        if (cd != want_cd) begin
            errors++;
            $display("FAIL ch%0d_cycle_done_count: got %0d want %0d", k, cd, want_cd);
        end
    endtask

    task automatic test_preempt_beep();
        int bad = 0, first = -1;
        logic [5:0] o, e, fo = '0, fe = '0;
        do_reset();
        start(3'b001);
        for (int i = 0; i < 6; i++) begin @(posedge clk); @(negedge clk); end
        bus.alarm_en = 3'b100;
        @(posedge clk);
        @(negedge clk);
        o = obs();
        checks++;
        if (o !== exp_vec(1, 6)) begin
            errors++;
            $display("FAIL preempt_first_edge: got %b want %b", o, exp_vec(1, 6));
        end
        for (int j = 0; j < 60; j++) begin
            @(posedge clk);
            @(negedge clk);
            o = obs();
            e = exp_vec(3, j);
            if (o !== e) begin
                bad++;
                if (first < 0) begin first = j; fo = o; fe = e; end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL preempt_beep_wave: %0d bad, first at %0d got %b want %b", bad, first, fo, fe);
        end
    endtask

    task automatic test_preempt_pause();
        int bad = 0, first = -1;
        logic [5:0] o, e, fo = '0, fe = '0;
        do_reset();
        start(3'b001);
        for (int i = 0; i <= 20; i++) begin @(posedge clk); @(negedge clk); end
        bus.alarm_en = 3'b100;
        for (int i = 21; i < 48; i++) begin
            @(posedge clk);
            @(negedge clk);
            o = obs();
            e = exp_vec(1, i);
            if (o !== e) begin
                bad++;
                if (first < 0) begin first = i; fo = o; fe = e; end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL pause_hold: %0d bad, first at %0d got %b want %b", bad, first, fo, fe);
        end
        @(posedge clk);
        @(negedge clk);
        o = obs();
        e = exp_vec(3, 0) | 6'b000001;
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL pause_switch_edge: got %b want %b", o, e);
        end
        bad = 0;
        first = -1;
        for (int j = 1; j < 50; j++) begin
            @(posedge clk);
            @(negedge clk);
            o = obs();
            e = exp_vec(3, j);
            if (o !== e) begin
                bad++;
                if (first < 0) begin first = j; fo = o; fe = e; end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL pause_switch_wave: %0d bad, first at %0d got %b want %b", bad, first, fo, fe);
        end
    endtask

    task automatic test_abort();
        int stray = 0;
        logic [5:0] o;
        do_reset();
        start(3'b001);
        for (int i = 0; i < 6; i++) begin @(posedge clk); @(negedge clk); end
        bus.alarm_en = 3'b000;
        @(posedge clk);
        @(negedge clk);
        o = obs();
        checks++;
        if (o !== exp_vec(1, 6)) begin
            errors++;
            $display("FAIL abort_first_edge: got %b want %b", o, exp_vec(1, 6));
        end
        @(posedge clk);
        @(negedge clk);
        o = obs();
        checks++;
        if (o !== 6'b0) begin
            errors++;
            $display("FAIL abort_idle: got %b want 000000", o);
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (obs() !== 6'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL abort_stays_idle: got %0d active samples want 0", stray);
        end
    endtask

    task automatic test_reset_mid_gap();
        int bad = 0, first = -1;
        logic [5:0] o, e, fo = '0, fe = '0;
        do_reset();
        start(3'b010);
        for (int i = 0; i <= 18; i++) begin @(posedge clk); @(negedge clk); end
        o = obs();
        checks++;
        if (o !== exp_vec(2, 18)) begin
            errors++;
            $display("FAIL gap_before_reset: got %b want %b", o, exp_vec(2, 18));
        end
        #2 rst = 1'b1;
        #1 o = obs();
        checks++;
        if (o !== 6'b0) begin
            errors++;
            $display("FAIL async_reset_immediate: got %b want 000000", o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        o = obs();
        checks++;
        if (o !== 6'b0) begin
            errors++;
            $display("FAIL resume_first_edge: got %b want 000000", o);
        end
        for (int j = 0; j < 72; j++) begin
            @(posedge clk);
            @(negedge clk);
            o = obs();
            e = exp_vec(2, j);
            if (o !== e) begin
                bad++;
                if (first < 0) begin first = j; fo = o; fe = e; end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL resume_wave: %0d bad, first at %0d got %b want %b", bad, first, fo, fe);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.alarm_en = 3'b000;
        test_reset();
        test_channel(3'b001, 1, 110, 2);
        test_channel(3'b100, 3, 200, 2);
        test_channel(3'b011, 2, 80, 1);
        test_preempt_beep();
        test_preempt_pause();
        test_abort();
        test_reset_mid_gap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
